// File: rtl/bpsk_pkg.sv
// Shared BPSK constants, receiver state enum and the sine table
// used by both the modulator and the receiver.
package bpsk_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int SINE_RESOLUTION = 64;
  localparam int WAVELENGTH      = 16;
  localparam int PACKET_SIZE     = 184;
  localparam logic [7:0] SYNC_WORD = 8'hA5;

  localparam int PH_W    = $clog2(SINE_RESOLUTION);
  localparam int PH_STEP = SINE_RESOLUTION / WAVELENGTH;
  localparam int SC_W    = $clog2(WAVELENGTH);
  localparam int PROD_W  = 2 * DATA_WIDTH;
  localparam int ACC_W   = PROD_W + $clog2(WAVELENGTH);
  localparam int CNT_W   = $clog2(PACKET_SIZE);

  typedef enum logic [1:0] {
    HUNT,
    COLLECT,
    HOLD
  } rx_state_e;

  // First quadrant of round(127*sin(2*pi*i/64)), i = 0..16.
  function automatic logic signed [DATA_WIDTH-1:0] quarter_sine(
    input logic [4:0] r
  );
    case (r)
      5'd0:    return 8'sd0;
      5'd1:    return 8'sd12;
      5'd2:    return 8'sd25;
      5'd3:    return 8'sd37;
      5'd4:    return 8'sd49;
      5'd5:    return 8'sd60;
      5'd6:    return 8'sd71;
      5'd7:    return 8'sd81;
      5'd8:    return 8'sd90;
      5'd9:    return 8'sd98;
      5'd10:   return 8'sd106;
      5'd11:   return 8'sd112;
      5'd12:   return 8'sd117;
      5'd13:   return 8'sd122;
      5'd14:   return 8'sd125;
      5'd15:   return 8'sd126;
      default: return 8'sd127;
    endcase
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sine_at(
    input logic [PH_W-1:0] idx
  );
    logic [4:0] r;
    r = {1'b0, idx[3:0]};
    case (idx[5:4])
      2'd0:    return quarter_sine(r);
      2'd1:    return quarter_sine(5'd16 - r);
      2'd2:    return -quarter_sine(r);
      default: return -quarter_sine(5'd16 - r);
    endcase
  endfunction

endpackage

// File: rtl/bpsk_receiver_symbol_correlator.sv
// Coherent symbol correlator: phase stepping, multiply,
// accumulate and per-symbol bit decision.
module symbol_correlator
  import bpsk_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  sample_en,
  input  logic                  flush,
  output logic                  bit_out,
  output logic                  bit_valid
);

  localparam logic [PH_W-1:0] PH_INC  = PH_W'(PH_STEP);
  localparam logic [PH_W-1:0] PH_TOP  = PH_W'(SINE_RESOLUTION - PH_STEP);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(WAVELENGTH - 1);

  if (SINE_RESOLUTION % WAVELENGTH != 0) begin : g_bad_res
    $error("SINE_RESOLUTION must be a multiple of WAVELENGTH");
  end

  logic [PH_W-1:0]          ph_q, ph_d;
  logic [SC_W-1:0]          sc_q, sc_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     pv_q, pv_d;
  logic                     last_q, last_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     bit_q, bit_d;
  logic                     bv_q, bv_d;

  logic signed [DATA_WIDTH-1:0] sine_v;
  logic signed [PROD_W-1:0]     samp_x, sine_x;

  always_comb begin
    sine_v  = sine_at(ph_q);
    samp_x  = {{DATA_WIDTH{sample[DATA_WIDTH-1]}}, sample};
    sine_x  = {{DATA_WIDTH{sine_v[DATA_WIDTH-1]}}, sine_v};
    acc_sum = acc_q
            + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    ph_d   = ph_q;
    sc_d   = sc_q;
    prod_d = prod_q;
    pv_d   = 1'b0;
    last_d = 1'b0;
    acc_d  = acc_q;
    bit_d  = bit_q;
    bv_d   = 1'b0;

    if (sample_en) begin
      prod_d = samp_x * sine_x;
      pv_d   = 1'b1;
      last_d = (sc_q == SC_LAST);
      ph_d   = (ph_q == PH_TOP) ? '0 : ph_q + PH_INC;
      sc_d   = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
    end

    // Decide on the running sum so the next product starts a fresh symbol.
    if (pv_q) begin
      if (last_q) begin
        acc_d = '0;
        bv_d  = 1'b1;
        bit_d = !acc_sum[ACC_W-1] && (acc_sum != '0);
      end else begin
        acc_d = acc_sum;
      end
    end

    if (flush) begin
      ph_d   = '0;
      sc_d   = '0;
      pv_d   = 1'b0;
      last_d = 1'b0;
      acc_d  = '0;
      bv_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q   <= '0;
      sc_q   <= '0;
      prod_q <= '0;
      pv_q   <= 1'b0;
      last_q <= 1'b0;
      acc_q  <= '0;
      bit_q  <= 1'b0;
      bv_q   <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      sc_q   <= sc_d;
      prod_q <= prod_d;
      pv_q   <= pv_d;
      last_q <= last_d;
      acc_q  <= acc_d;
      bit_q  <= bit_d;
      bv_q   <= bv_d;
    end
  end

  assign bit_out   = bit_q;
  assign bit_valid = bv_q;

endmodule

// File: rtl/bpsk_receiver.sv
// BPSK receiver: correlator, sync hunt, packet assembly and
// valid/ready hand-off to the packet consumer.
module bpsk_receiver
  import bpsk_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  sample,
  input  logic                   sample_valid,
  output logic [PACKET_SIZE-1:0] packet,
  output logic                   packet_valid,
  input  logic                   packet_ready,
  output logic                   locked,
  output logic                   overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACKET_SIZE - 1);

  rx_state_e state_q, state_d;

  // The eighth bit of the sync window is the incoming decision itself.
  logic [6:0]             hist_q, hist_d;
  logic [7:0]             hist_sh;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PACKET_SIZE-1:0] pkt_q, pkt_d;
  logic                   ovr_q, ovr_d;

  logic bit_out;
  logic bit_valid;
  logic corr_en;
  logic corr_flush;

  assign corr_en    = sample_valid && (state_q != HOLD);
  assign corr_flush = (state_q == HOLD);

  symbol_correlator u_corr (
    .clk       (clk),
    .rst       (rst),
    .sample    (sample),
    .sample_en (corr_en),
    .flush     (corr_flush),
    .bit_out   (bit_out),
    .bit_valid (bit_valid)
  );

  assign hist_sh = {hist_q, bit_out};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT: begin
        if (bit_valid && hist_sh == SYNC_WORD) state_d = COLLECT;
      end
      COLLECT: begin
        if (bit_valid && cnt_q == CNT_LAST) state_d = HOLD;
      end
      HOLD: begin
        if (packet_ready) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    locked       = (state_q != HUNT);
    packet_valid = (state_q == HOLD);
  end

  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    pkt_d  = pkt_q;
    ovr_d  = ovr_q;
    unique case (state_q)
      HUNT: begin
        cnt_d = '0;
        if (bit_valid) hist_d = hist_sh[6:0];
      end
      COLLECT: begin
        if (bit_valid) begin
          pkt_d = {pkt_q[PACKET_SIZE-2:0], bit_out};
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        hist_d = '0;
        cnt_d  = '0;
        if (sample_valid) ovr_d = 1'b1;
      end
      default: begin
        hist_d = '0;
        cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      cnt_q  <= '0;
      pkt_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      pkt_q  <= pkt_d;
      ovr_q  <= ovr_d;
    end
  end

  assign packet  = pkt_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_bpsk_receiver.sv
// Directed bench for bpsk_receiver: a symbol-level model checked every
// cycle, plus hand-computed packet and latency expectations.
module tb_bpsk_receiver;
  import bpsk_pkg::*;

  localparam real TWO_PI = 6.283185307179586;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [DATA_WIDTH-1:0]  sample = '0;
  logic                   sample_valid = 1'b0;
  logic                   packet_ready = 1'b0;
  logic [PACKET_SIZE-1:0] packet;
  logic                   packet_valid;
  logic                   locked;
  logic                   overrun;

  bpsk_receiver dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .packet       (packet),
    .packet_valid (packet_valid),
    .packet_ready (packet_ready),
    .locked       (locked),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int edge_n = 0;
  int lock_edge = -1;
  int s0 = 0;
  int last_e = 0;

  always @(posedge clk) edge_n++;

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (edge %0d)",
               name, got, exp, edge_n);
    end
  endtask

  task automatic chkp(input string name,
                      input logic [PACKET_SIZE-1:0] got,
                      input logic [PACKET_SIZE-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)",
               name, got, exp, edge_n);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model: correlate each symbol against an ideal sine, decide, then frame.
  typedef struct {
    int due;
    bit b;
  } dec_t;

  dec_t                   m_dq[$];
  bit                     m_hist[$];
  bit                     m_bits[$];
  int                     m_st = 0;
  bit                     m_ovr = 1'b0;
  logic [PACKET_SIZE-1:0] m_pkt = '0;
  real                    m_acc = 0.0;
  int                     m_n = 0;
  int                     m_cyc = 0;

  function automatic logic [7:0] hist_byte();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[6:0], m_hist[i]};
    return v;
  endfunction

  task automatic take_bit(input bit b);
    if (m_st == 0) begin
      m_hist.push_back(b);
      if (m_hist.size() > 8) void'(m_hist.pop_front());
      if (m_hist.size() == 8 && hist_byte() == SYNC_WORD) begin
        m_st = 1;
        m_bits.delete();
      end
    end else begin
      m_bits.push_back(b);
      if (m_bits.size() == PACKET_SIZE) begin
        for (int i = 0; i < PACKET_SIZE; i++)
          m_pkt[PACKET_SIZE-1-i] = m_bits[i];
        m_st = 2;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dq.delete();
      m_hist.delete();
      m_bits.delete();
      m_st  = 0;
      m_ovr = 1'b0;
      m_pkt = '0;
      m_acc = 0.0;
      m_n   = 0;
      m_cyc = 0;
    end else if (m_st == 2) begin
      if (sample_valid) m_ovr = 1'b1;
      if (packet_ready) m_st = 0;
      m_dq.delete();
      m_hist.delete();
      m_acc = 0.0;
      m_n   = 0;
      m_cyc++;
    end else begin
      dec_t d;
      if (m_dq.size() > 0 && m_dq[0].due == m_cyc) begin
        d = m_dq.pop_front();
        take_bit(d.b);
      end
      if (sample_valid) begin
        m_acc += $itor($signed(sample))
               * $sin(TWO_PI * m_n / WAVELENGTH);
        m_n++;
        if (m_n == WAVELENGTH) begin
          d.due = m_cyc + 2;
          d.b   = (m_acc > 0.0);
          m_dq.push_back(d);
          m_acc = 0.0;
          m_n   = 0;
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    chk1("locked", locked, m_st != 0);
    chk1("packet_valid", packet_valid, m_st == 2);
    chk1("overrun", overrun, m_ovr);
    if (m_st == 2 || rst) chkp("packet", packet, m_pkt);
  end

  always @(negedge clk)
    if (!rst && locked && lock_edge < 0) lock_edge = edge_n;

  // Stimulus
  bit txq[$];

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) txq.push_back(b[i]);
  endtask

  task automatic push_alt(input int n);
    for (int i = 0; i < n; i++) txq.push_back(i % 2 == 0);
  endtask

  task automatic push_ones(input int n);
    for (int i = 0; i < n; i++) txq.push_back(1'b1);
  endtask

  function automatic int tx_level(input int n, input bit b);
    real x;
    int  v;
    x = 127.0 * $sin(TWO_PI * n / WAVELENGTH);
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    return b ? v : -v;
  endfunction

  task automatic drive(input logic v, input logic [DATA_WIDTH-1:0] s);
    @(posedge clk);
    #1;
    sample_valid = v;
    sample       = s;
  endtask

  task automatic play(input bit gapped);
    int k;
    bit first;
    k = 0;
    first = 1'b1;
    foreach (txq[i]) begin
      for (int n = 0; n < WAVELENGTH; n++) begin
        if (gapped && (k % 3 == 2)) begin
          drive(1'b0, DATA_WIDTH'($urandom));
          k++;
        end
        drive(1'b1, DATA_WIDTH'(tx_level(n, txq[i])));
        if (first) begin
          s0 = edge_n + 1;
          first = 1'b0;
        end
        last_e = edge_n + 1;
        k++;
      end
    end
    drive(1'b0, '0);
    txq.delete();
  endtask

  task automatic wait_valid(input string name, input int exp_edge);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!packet_valid && t < 400);
    chk1({name, "_valid_seen"}, packet_valid, 1'b1);
    chki({name, "_valid_edge"}, edge_n, exp_edge);
  endtask

  task automatic ack(input string name);
    @(posedge clk);
    #1 packet_ready = 1'b1;
    @(posedge clk);
    #1 packet_ready = 1'b0;
    @(negedge clk);
    chk1({name, "_ack_valid"}, packet_valid, 1'b0);
    chk1({name, "_ack_locked"}, locked, 1'b0);
  endtask

  initial begin
    logic [PACKET_SIZE-1:0] lit_alt;
    logic [PACKET_SIZE-1:0] lit_ones;
    logic [PACKET_SIZE-1:0] lit_zero;
    lit_alt  = {92{2'b10}};
    lit_ones = '1;
    lit_zero = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chkp("reset_packet", packet, lit_zero);
    chk1("reset_valid", packet_valid, 1'b0);
    chk1("reset_locked", locked, 1'b0);
    chk1("reset_overrun", overrun, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Clean frame
    lock_edge = -1;
    push_byte(SYNC_WORD);
    push_alt(PACKET_SIZE);
    play(1'b0);
    chki("clean_lock_edge", lock_edge, s0 + 8 * WAVELENGTH + 1);
    wait_valid("clean", last_e + 2);
    chkp("clean_packet", packet, lit_alt);
    chkp("clean_model", m_pkt, lit_alt);
    ack("clean");

    // False sync words ahead of the real one
    lock_edge = -1;
    push_byte(8'hA4);
    push_byte(8'h00);
    push_byte(SYNC_WORD);
    push_ones(PACKET_SIZE);
    play(1'b0);
    chki("false_lock_edge", lock_edge, s0 + 24 * WAVELENGTH + 1);
    wait_valid("false", last_e + 2);
    chkp("false_packet", packet, lit_ones);
    chkp("false_model", m_pkt, lit_ones);
    ack("false");

    // Gapped samples, then backpressure with samples still arriving
    push_byte(SYNC_WORD);
    push_alt(PACKET_SIZE);
    play(1'b1);
    wait_valid("gapped", last_e + 2);
    chkp("gapped_packet", packet, lit_alt);
    for (int i = 0; i < 50; i++) drive(1'b1, DATA_WIDTH'($urandom));
    drive(1'b0, '0);
    @(negedge clk);
    chkp("bp_packet", packet, lit_alt);
    chk1("bp_overrun", overrun, 1'b1);
    chk1("bp_valid", packet_valid, 1'b1);
    chk1("bp_locked", locked, 1'b1);
    ack("bp");
    chk1("bp_overrun_sticky", overrun, 1'b1);

    // Zero input, with ready held high while idle
    packet_ready = 1'b1;
    for (int i = 0; i < 8 * WAVELENGTH; i++) drive(1'b1, '0);
    drive(1'b0, '0);
    repeat (4) @(negedge clk);
    chk1("zero_no_lock", locked, 1'b0);
    chk1("zero_no_valid", packet_valid, 1'b0);
    packet_ready = 1'b0;

    // Reset in the middle of a payload
    push_byte(SYNC_WORD);
    push_alt(100);
    play(1'b0);
    chk1("mid_locked", locked, 1'b1);
    #2 rst = 1'b1;
    #1;
    chkp("mid_rst_packet", packet, lit_zero);
    chk1("mid_rst_valid", packet_valid, 1'b0);
    chk1("mid_rst_locked", locked, 1'b0);
    chk1("mid_rst_overrun", overrun, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    lock_edge = -1;
    push_byte(SYNC_WORD);
    push_alt(PACKET_SIZE);
    play(1'b0);
    chki("post_lock_edge", lock_edge, s0 + 8 * WAVELENGTH + 1);
    wait_valid("post", last_e + 2);
    chkp("post_packet", packet, lit_alt);
    ack("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bpsk_receiver.md
# bpsk_receiver

Receive-side counterpart of the BPSK transmitter. It takes the sampled carrier stream, coherently correlates each symbol against the shared sine table, and slices bits. It hunts for a sync word, then assembles a PACKET_SIZE-bit packet and hands it to the downstream packet consumer with a valid/ready handshake. It sits between the ADC sample interface and the packet deserializer / UART return path.

## Interface
- DATA_WIDTH, 8: signed sample width, matching the transmitter DAC width.
- SINE_RESOLUTION, 64: number of entries in the shared sine table.
- WAVELENGTH, 16: valid samples per carrier period. One symbol is one period. SINE_RESOLUTION % WAVELENGTH == 0 is required, enforced by an elaboration assertion.
- PACKET_SIZE, 184: payload bits per packet.
- SYNC_WORD, 8'hA5: 8-bit preamble that precedes every payload, MSB first.

- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high. Clears all state.
- sample, input, DATA_WIDTH: signed two's-complement carrier sample.
- sample_valid, input, 1: `sample` is consumed this cycle.
- packet, output, PACKET_SIZE: assembled payload. The first received bit is in the MSB.
- packet_valid, output, 1: `packet` is stable and complete.
- packet_ready, input, 1: consumer accepts the packet.
- locked, output, 1: sync word found; a payload is being collected or held.
- overrun, output, 1: sticky flag, set when samples arrive while a packet is held.

## Operation
- Phase index `ph` steps through the table. It advances by SINE_RESOLUTION/WAVELENGTH per valid sample and wraps modulo SINE_RESOLUTION. The symbol counter `sc` counts 0..WAVELENGTH-1 on valid samples only.
- Product: sample × sine[ph], signed, 2·DATA_WIDTH bits, registered.
- Accumulator width: 2·DATA_WIDTH + $clog2(WAVELENGTH). Saturation is not needed.
- Decision when the product of sample sc==WAVELENGTH-1 is accumulated:
  - bit = 1 if acc > 0 (phase 0).
  - bit = 0 if acc ≤ 0 (phase 180; zero resolves to 0).
  - The accumulator then restarts from the next product without dropping one.
- States:
  - HUNT: 8-bit history register shifts in each bit. It is cleared on entry, so a match needs 8 fresh bits. History == SYNC_WORD goes to COLLECT, sets locked=1 and clears the bit counter.
  - COLLECT: each decided bit shifts into `packet` from the LSB, so the first bit ends up in the MSB. After PACKET_SIZE bits, go to HOLD and set packet_valid=1.
  - HOLD: `packet` is frozen and samples are discarded (ph and sc do not advance). sample_valid=1 in HOLD sets overrun. When packet_valid && packet_ready: clear packet_valid and locked, then go to HUNT.
- A symbol boundary is the first valid sample after reset and after each HOLD exit. ph=0 and sc=0 there.
- Reset, including mid-packet: state=HUNT, ph=sc=acc=0, history=0, packet=0, packet_valid=0, locked=0, overrun=0.

## Timing
- Sample accepted at cycle k → product registered at k+1 → accumulated at k+2.
- Bit decision is visible one cycle after the last sample of its symbol is accumulated. That is 2 cycles after the symbol's final sample is accepted.
- locked rises on the cycle after the decision that completes the sync match.
- packet_valid rises on the cycle after the decision of payload bit PACKET_SIZE-1.
- Handshake:
  - packet_valid stays high until a cycle with packet_ready=1. packet_valid falls the next cycle.
  - packet_ready while packet_valid=0 is ignored.
  - A packet accepted in the same cycle it becomes valid is legal.
- Gaps in sample_valid stall ph, sc and accumulation with no loss. The pipeline drains in-flight products normally.
- Wrap-around: ph wraps with no skip, e.g. 60 → 0 for step 4 in a 64-entry table.

## Structure
- Shared package bpsk_pkg:
  - DATA_WIDTH, SINE_RESOLUTION, WAVELENGTH, PACKET_SIZE, SYNC_WORD.
  - The receiver state enum (HUNT, COLLECT, HOLD).
  - The sine table constant/function, shared with signal_modulator so both ends use identical coefficients.
- Sub-module symbol_correlator: phase stepping, multiply, accumulate and bit decision. Outputs are a bit plus a one-cycle bit_valid strobe.
- The top level holds the framing FSM, history register, packet shift register and handshake.

## Test plan
- Clean frame: SYNC 8'hA5 then 184 bits alternating 1,0 at full amplitude (±127 peak), sample_valid=1 continuous → locked high after bit 8; packet == {92{2'b10}}; packet_valid rises exactly 2 cycles after the last sample plus 1.
- False sync: bits 8'hA4, 8'h00, then 8'hA5 and an all-ones payload → locked only after the true A5; packet == all ones.
- Gapped samples: same frame with sample_valid deasserted every third cycle → identical packet; latency stretched only by the gaps.
- Backpressure: packet_ready=0 for 50 cycles with samples still driven → packet stable, overrun=1, and after ready the FSM returns to HUNT with locked=0.
- Zero input: sample=0 for 8 symbols → all decisions are 0; no lock with SYNC_WORD=8'hA5.
- Reset mid-COLLECT at bit 100 → all outputs 0 the same cycle (async); the next clean frame decodes correctly.
